// File: rtl/pipe_control_unit.sv
// Pipelined main control for the 5-stage MIPS core: ID decode, ID/EX -> EX/MEM -> MEM/WB
// control registers, load-use stall, branch/jump squash and a saturating stall counter.
module pipe_control_unit #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        opcode,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              branch_taken,
    output logic              ex_reg_dst,
    output logic              ex_alu_src,
    output logic [1:0]        ex_alu_op,
    output logic              mem_branch,
    output logic              mem_branch_ne,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_mem_to_reg,
    output logic              wb_reg_write,
    output logic              id_jump,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101,
        OP_ADDI  = 6'b001000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       branch_ne;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
    } idex_t;

    typedef struct packed {
        logic branch;
        logic branch_ne;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } exmem_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } memwb_t;

    idex_t             r_idex;
    exmem_t            r_exmem;
    memwb_t            r_memwb;
    logic [REG_AW-1:0] r_id_ex_rt;
    logic [CNT_W-1:0]  r_stall_count;

    idex_t             w_dec;
    exmem_t            w_exmem_d;
    logic              w_is_j;
    logic              w_rt_src;
    logic              w_rs_match;
    logic              w_rt_match;
    logic              w_hazard;
    logic              w_stall;

    always_comb begin
        w_dec    = '0;
        w_is_j   = 1'b0;
        w_rt_src = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                w_dec.reg_dst   = 1'b1;
                w_dec.alu_op    = 2'b10;
                w_dec.reg_write = 1'b1;
                w_rt_src        = 1'b1;
            end
            OP_LW: begin
                w_dec.alu_src    = 1'b1;
                w_dec.mem_read   = 1'b1;
                w_dec.mem_to_reg = 1'b1;
                w_dec.reg_write  = 1'b1;
            end
            OP_SW: begin
                w_dec.alu_src   = 1'b1;
                w_dec.mem_write = 1'b1;
                w_rt_src        = 1'b1;
            end
            OP_BEQ: begin
                w_dec.alu_op = 2'b01;
                w_dec.branch = 1'b1;
                w_rt_src     = 1'b1;
            end
            OP_BNE: begin
                w_dec.alu_op    = 2'b01;
                w_dec.branch_ne = 1'b1;
                w_rt_src        = 1'b1;
            end
            OP_ADDI: begin
                w_dec.alu_src   = 1'b1;
                w_dec.reg_write = 1'b1;
            end
            OP_J:    w_is_j = 1'b1;
            default: ;
        endcase
    end

    // j reads no registers, so it can never raise a hazard; rt is a source only for R/sw/beq/bne.
    assign w_rs_match = ~w_is_j & (r_id_ex_rt == if_id_rs);
    assign w_rt_match = w_rt_src & (r_id_ex_rt == if_id_rt);
    assign w_hazard   = r_idex.mem_read & (r_id_ex_rt != '0) & (w_rs_match | w_rt_match);
    assign w_stall    = w_hazard & ~branch_taken;

    assign id_jump     = w_is_j & ~branch_taken & ~w_hazard;
    assign pc_write    = ~w_stall;
    assign if_id_write = ~w_stall;
    assign if_id_flush = branch_taken | id_jump;

    always_comb begin
        w_exmem_d            = '0;
        w_exmem_d.branch     = r_idex.branch;
        w_exmem_d.branch_ne  = r_idex.branch_ne;
        w_exmem_d.mem_read   = r_idex.mem_read;
        w_exmem_d.mem_write  = r_idex.mem_write;
        w_exmem_d.mem_to_reg = r_idex.mem_to_reg;
        w_exmem_d.reg_write  = r_idex.reg_write;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idex        <= '0;
            r_exmem       <= '0;
            r_memwb       <= '0;
            r_id_ex_rt    <= '0;
            r_stall_count <= '0;
        end else begin
            if (branch_taken || w_stall) begin
                r_idex <= '0;
            end else begin
                r_idex     <= w_dec;
                r_id_ex_rt <= if_id_rt;
            end
            r_exmem            <= branch_taken ? exmem_t'('0) : w_exmem_d;
            r_memwb.mem_to_reg <= r_exmem.mem_to_reg;
            r_memwb.reg_write  <= r_exmem.reg_write;
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign ex_reg_dst    = r_idex.reg_dst;
    assign ex_alu_src    = r_idex.alu_src;
    assign ex_alu_op     = r_idex.alu_op;
    assign mem_branch    = r_exmem.branch;
    assign mem_branch_ne = r_exmem.branch_ne;
    assign mem_read      = r_exmem.mem_read;
    assign mem_write     = r_exmem.mem_write;
    assign wb_mem_to_reg = r_memwb.mem_to_reg;
    assign wb_reg_write  = r_memwb.reg_write;
    assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: two instances share stimulus, one with a 2-bit
// stall counter to exercise saturation.
module tb_pipe_control_unit;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       branch_taken;

    logic        ex_reg_dst0, ex_alu_src0, mem_branch0, mem_branch_ne0, mem_read0, mem_write0;
    logic        wb_mem_to_reg0, wb_reg_write0, id_jump0, pc_write0, if_id_write0, if_id_flush0;
    logic [1:0]  ex_alu_op0;
    logic [15:0] stall_count0;
    logic        ex_reg_dst1, ex_alu_src1, mem_branch1, mem_branch_ne1, mem_read1, mem_write1;
    logic        wb_mem_to_reg1, wb_reg_write1, id_jump1, pc_write1, if_id_write1, if_id_flush1;
    logic [1:0]  ex_alu_op1;
    logic [1:0]  stall_count1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_control_unit u0 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .branch_taken(branch_taken), .ex_reg_dst(ex_reg_dst0), .ex_alu_src(ex_alu_src0),
        .ex_alu_op(ex_alu_op0), .mem_branch(mem_branch0), .mem_branch_ne(mem_branch_ne0),
        .mem_read(mem_read0), .mem_write(mem_write0), .wb_mem_to_reg(wb_mem_to_reg0),
        .wb_reg_write(wb_reg_write0), .id_jump(id_jump0), .pc_write(pc_write0),
        .if_id_write(if_id_write0), .if_id_flush(if_id_flush0), .stall_count(stall_count0)
    );

    pipe_control_unit #(.CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .branch_taken(branch_taken), .ex_reg_dst(ex_reg_dst1), .ex_alu_src(ex_alu_src1),
        .ex_alu_op(ex_alu_op1), .mem_branch(mem_branch1), .mem_branch_ne(mem_branch_ne1),
        .mem_read(mem_read1), .mem_write(mem_write1), .wb_mem_to_reg(wb_mem_to_reg1),
        .wb_reg_write(wb_reg_write1), .id_jump(id_jump1), .pc_write(pc_write1),
        .if_id_write(if_id_write1), .if_id_flush(if_id_flush1), .stall_count(stall_count1)
    );

    // Grouped views: ex={reg_dst,alu_src,alu_op} mem={branch,branch_ne,read,write}
    // wb={mem_to_reg,reg_write} ctl={id_jump,pc_write,if_id_write,if_id_flush}
    logic [3:0] ex0, ex1, mem0, mem1, ctl0, ctl1;
    logic [1:0] wb0, wb1;
    assign ex0  = {ex_reg_dst0, ex_alu_src0, ex_alu_op0};
    assign ex1  = {ex_reg_dst1, ex_alu_src1, ex_alu_op1};
    assign mem0 = {mem_branch0, mem_branch_ne0, mem_read0, mem_write0};
    assign mem1 = {mem_branch1, mem_branch_ne1, mem_read1, mem_write1};
    assign wb0  = {wb_mem_to_reg0, wb_reg_write0};
    assign wb1  = {wb_mem_to_reg1, wb_reg_write1};
    assign ctl0 = {id_jump0, pc_write0, if_id_write0, if_id_flush0};
    assign ctl1 = {id_jump1, pc_write1, if_id_write1, if_id_flush1};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic c_ex(input logic [3:0] e);
        chk("ex0", 16'(ex0), 16'(e));
        chk("ex1", 16'(ex1), 16'(e));
    endtask

    task automatic c_mem(input logic [3:0] e);
        chk("mem0", 16'(mem0), 16'(e));
        chk("mem1", 16'(mem1), 16'(e));
    endtask

    task automatic c_wb(input logic [1:0] e);
        chk("wb0", 16'(wb0), 16'(e));
        chk("wb1", 16'(wb1), 16'(e));
    endtask

    task automatic c_ctl(input logic [3:0] e);
        chk("ctl0", 16'(ctl0), 16'(e));
        chk("ctl1", 16'(ctl1), 16'(e));
    endtask

    task automatic c_cnt(input logic [15:0] e0, input logic [1:0] e1);
        chk("cnt16", stall_count0, e0);
        chk("cnt2", 16'(stall_count1), 16'(e1));
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic bt);
        opcode       = op;
        if_id_rs     = rs;
        if_id_rt     = rt;
        branch_taken = bt;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(OP_R, 5'd1, 5'd2, 1'b0);
        tick;
        tick;
        c_ex(4'b0000); c_mem(4'b0000); c_wb(2'b00); c_ctl(4'b0110); c_cnt(16'd0, 2'd0);

        // R-type flows through EX, MEM, WB
        rst_n = 1'b1;
        tick;
        c_ex(4'b1010); c_mem(4'b0000); c_wb(2'b00);
        drive(OP_BAD, 5'd1, 5'd2, 1'b0);
        c_ctl(4'b0110);
        tick;
        c_ex(4'b0000); c_mem(4'b0000);
        tick;
        c_wb(2'b01); c_ex(4'b0000);
        tick;
        c_wb(2'b00);

        // lw r5 then add using rs=5: one-cycle stall with bubble
        drive(OP_LW, 5'd0, 5'd5, 1'b0);
        c_ctl(4'b0110);
        tick;
        c_ex(4'b0100);
        drive(OP_R, 5'd5, 5'd7, 1'b0);
        c_ctl(4'b0000); c_cnt(16'd0, 2'd0);
        tick;
        c_ex(4'b0000); c_mem(4'b0010); c_cnt(16'd1, 2'd1); c_ctl(4'b0110);
        tick;
        c_ex(4'b1010); c_mem(4'b0000); c_wb(2'b11); c_cnt(16'd1, 2'd1);

        // addi uses rt as destination only; rt=0 never hazards
        drive(OP_LW, 5'd0, 5'd5, 1'b0);
        tick;
        drive(OP_ADDI, 5'd3, 5'd5, 1'b0);
        c_ctl(4'b0110);
        tick;
        c_ex(4'b0100); c_cnt(16'd1, 2'd1);
        drive(OP_LW, 5'd0, 5'd0, 1'b0);
        tick;
        drive(OP_R, 5'd0, 5'd0, 1'b0);
        c_ctl(4'b0110);
        tick;
        c_cnt(16'd1, 2'd1);

        // sw reads rt: rt match stalls
        drive(OP_LW, 5'd0, 5'd5, 1'b0);
        tick;
        drive(OP_SW, 5'd1, 5'd5, 1'b0);
        c_ctl(4'b0000);
        tick;
        c_ex(4'b0000); c_cnt(16'd2, 2'd2); c_ctl(4'b0110);
        tick;
        c_ex(4'b0100);

        // bne bundle
        drive(OP_BNE, 5'd1, 5'd2, 1'b0);
        tick;
        c_ex(4'b0001);
        drive(OP_BAD, 5'd0, 5'd0, 1'b0);
        tick;
        c_mem(4'b0100);

        // taken branch overrides a coincident load-use hazard
        drive(OP_BEQ, 5'd1, 5'd2, 1'b0);
        tick;
        c_ex(4'b0001);
        drive(OP_LW, 5'd0, 5'd5, 1'b0);
        tick;
        c_mem(4'b1000); c_ex(4'b0100);
        drive(OP_R, 5'd5, 5'd6, 1'b1);
        c_ctl(4'b0111);
        drive(OP_J, 5'd0, 5'd0, 1'b1);
        c_ctl(4'b0111);
        drive(OP_R, 5'd5, 5'd6, 1'b1);
        tick;
        c_ex(4'b0000); c_mem(4'b0000); c_wb(2'b00); c_cnt(16'd2, 2'd2);

        // jump
        drive(OP_R, 5'd5, 5'd6, 1'b0);
        c_ctl(4'b0110);
        tick;
        c_ex(4'b1010);
        drive(OP_J, 5'd0, 5'd0, 1'b0);
        c_ctl(4'b1111);
        tick;
        c_ex(4'b0000);
        drive(OP_BAD, 5'd0, 5'd0, 1'b0);
        c_ctl(4'b0110);
        tick;
        c_ex(4'b0000); c_mem(4'b0000);
        tick;
        c_wb(2'b00);

        // counter saturation on the 2-bit instance
        rst_n = 1'b0;
        #1;
        c_cnt(16'd0, 2'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(OP_LW, 5'd0, 5'd5, 1'b0);
            tick;
            drive(OP_R, 5'd5, 5'd0, 1'b0);
            c_ctl(4'b0000);
            tick;
            c_cnt(16'(i + 1), (i + 1 > 3) ? 2'd3 : 2'(i + 1));
        end

        // asynchronous reset in the middle of a stall
        drive(OP_LW, 5'd0, 5'd5, 1'b0);
        tick;
        drive(OP_R, 5'd5, 5'd0, 1'b0);
        c_ctl(4'b0000);
        rst_n = 1'b0;
        #1;
        c_cnt(16'd0, 2'd0); c_ctl(4'b0110); c_ex(4'b0000); c_mem(4'b0000); c_wb(2'b00);
        tick;
        rst_n = 1'b1;
        c_ex(4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
